// File: rtl/mem_bus_interface_pkg.sv
// rtl/mem_bus_interface_pkg.sv - shared bus-unit constants and state encoding
package mem_bus_interface_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_interface_wait_timer.sv
// rtl/mem_bus_interface_wait_timer.sv - wait-state counter; expire flags the last allowed ACCESS cycle
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - latches core address/data and runs a req/ack memory transaction with timeout
module mem_bus_interface #(
  parameter int DATA_WIDTH = mem_bus_interface_pkg::DATA_WIDTH,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   abl,
  input  logic [DATA_WIDTH-1:0]   abh,
  input  logic [DATA_WIDTH-1:0]   db,
  input  logic                    rw,
  input  logic                    sync,
  input  logic                    cyc_valid,
  output logic                    core_rdy,
  output logic [DATA_WIDTH-1:0]   dl,
  output logic [DATA_WIDTH-1:0]   ir,
  output logic                    bus_err,
  output logic [2*DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_we,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  import mem_bus_interface_pkg::*;

  bus_state_e                state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     dl_q, dl_d;
  logic [DATA_WIDTH-1:0]     ir_q, ir_d;
  logic                      rw_q, rw_d;
  logic                      sync_q, sync_d;
  logic                      tmr_clr, tmr_en, tmr_expire;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dl_q    <= '0;
      ir_q    <= '0;
      rw_q    <= 1'b1;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dl_q    <= dl_d;
      ir_q    <= ir_d;
      rw_q    <= rw_d;
      sync_q  <= sync_d;
    end
  end

  // Ack is checked before the timer so a reply on the final wait cycle still completes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dl_d    = dl_q;
    ir_d    = ir_q;
    rw_d    = rw_q;
    sync_d  = sync_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_valid) begin
          state_d = ACCESS;
          addr_d  = {abh, abl};
          wdata_d = db;
          rw_d    = rw;
          sync_d  = sync;
          tmr_clr = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (rw_q) begin
            dl_d = mem_rdata;
            if (sync_q) ir_d = mem_rdata;
          end
        end else if (tmr_expire) begin
          state_d = ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from state alone, keeping mem_ack off any combinational path.
  assign core_rdy  = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && !rw_q;
  assign bus_err   = (state_q == ERR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dl        = dl_q;
  assign ir        = ir_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - scoreboard bench for mem_bus_interface with randomized transactions
module tb_mem_bus_interface;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  abl = '0, abh = '0, db = '0;
  logic        rw = 1'b1, sync = 1'b0, cyc_valid = 1'b0;
  logic        core_rdy, bus_err, mem_we, mem_req;
  logic [7:0]  dl, ir, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  mem_bus_interface #(.DATA_WIDTH(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .abl(abl), .abh(abh), .db(db), .rw(rw), .sync(sync),
    .cyc_valid(cyc_valid), .core_rdy(core_rdy), .dl(dl), .ir(ir), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    logic [7:0] dl;
    logic [7:0] ir;
    int         req_cycles;
    int         err_pulses;
    int         busy_cycles;
  } comp_t;

  req_t  req_q[$];
  comp_t comp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] m_dl = '0;
  logic [7:0] m_ir = '0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the expected request when mem_req rises and the expected outcome when core_rdy returns.
  req_t cur_req;
  bit   prev_rdy = 1'b1, prev_req = 1'b0;
  int   busy_n = 0, req_n = 0, err_n = 0;

  always @(negedge clk) begin
    comp_t c;
    if (rst) begin
      prev_rdy = 1'b1; prev_req = 1'b0;
      busy_n = 0; req_n = 0; err_n = 0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          cur_req = req_q.pop_front();
          chk("req_addr", mem_addr, cur_req.addr);
          chk("req_we", mem_we, cur_req.we);
          if (cur_req.we) chk("req_wdata", mem_wdata, cur_req.wdata);
        end
      end else if (mem_req) begin
        chk("addr_stable", mem_addr, cur_req.addr);
        chk("we_stable", mem_we, cur_req.we);
      end
      if (!core_rdy) busy_n++;
      if (mem_req) req_n++;
      if (bus_err) err_n++;
      if (core_rdy && !prev_rdy) begin
        if (comp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          c = comp_q.pop_front();
          chk("dl", dl, c.dl);
          chk("ir", ir, c.ir);
          chk("req_cycles", req_n, c.req_cycles);
          chk("err_pulses", err_n, c.err_pulses);
          chk("busy_cycles", busy_n, c.busy_cycles);
        end
        busy_n = 0; req_n = 0; err_n = 0;
      end
      prev_rdy = core_rdy;
      prev_req = mem_req;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!core_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!core_rdy) chk("idle_timeout", 0, 1);
  endtask

  // w < MAX_WAIT: ack arrives in ACCESS cycle w (0-based); w >= MAX_WAIT: never acked.
  task automatic do_txn(input logic [15:0] addr, input logic r, input logic s,
                        input logic [7:0] wd, input int w, input logic [7:0] rd, input bit junk);
    req_t  rq;
    comp_t cp;
    int    k = 0;
    bit    done = 1'b0;
    wait_idle();
    {abh, abl} = addr; db = wd; rw = r; sync = s; cyc_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    rq.addr = addr; rq.we = !r; rq.wdata = wd;
    req_q.push_back(rq);
    if (w < MAX_WAIT) begin
      if (r) begin
        m_dl = rd;
        if (s) m_ir = rd;
      end
      cp.req_cycles = w + 1; cp.err_pulses = 0; cp.busy_cycles = w + 1;
    end else begin
      cp.req_cycles = MAX_WAIT; cp.err_pulses = 1; cp.busy_cycles = MAX_WAIT + 1;
    end
    cp.dl = m_dl; cp.ir = m_ir;
    comp_q.push_back(cp);
    @(negedge clk);
    for (int t = 0; t < MAX_WAIT + 4 && !done; t++) begin
      cyc_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        abl = 8'($urandom); abh = 8'($urandom); db = 8'($urandom);
        rw = 1'($urandom_range(0, 1));
      end
      if (k >= MAX_WAIT) mem_ack = 1'($urandom_range(0, 1));
      else               mem_ack = (k == w);
      mem_rdata = (k == w) ? rd : 8'($urandom);
      k++;
      @(negedge clk);
      if (core_rdy) done = 1'b1;
    end
    if (!done) chk("txn_timeout", 0, 1);
    cyc_valid = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1;
    chk("rst_core_rdy", core_rdy, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dl", dl, 0);
    chk("rst_ir", ir, 0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    do_txn(16'hFFFC, 1'b1, 1'b1, 8'h00, 0, 8'hA9, 1'b0);
    do_txn(16'h0200, 1'b0, 1'b0, 8'h55, 3, 8'hFF, 1'b0);
    do_txn(16'h4000, 1'b1, 1'b0, 8'h00, MAX_WAIT, 8'h77, 1'b0);
    do_txn(16'h4001, 1'b1, 1'b0, 8'h00, MAX_WAIT - 1, 8'h3C, 1'b0);
    do_txn(16'h0010, 1'b1, 1'b0, 8'h00, 1, 8'h11, 1'b1);
    do_txn(16'h0011, 1'b1, 1'b0, 8'h00, 0, 8'h22, 1'b1);
    wait_idle();

    // Reset in the middle of an ACCESS at 0x1234; a late ack must be ignored.
    mem_ack = 1'b0;
    {abh, abl} = 16'h1234; rw = 1'b1; sync = 1'b1; db = 8'h00; cyc_valid = 1'b1;
    req_q.push_back('{addr: 16'h1234, we: 1'b0, wdata: 8'h00});
    @(negedge clk);
    cyc_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_core_rdy", core_rdy, 1);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_dl", dl, 0);
    chk("midrst_ir", ir, 0);
    m_dl = '0; m_ir = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_core_rdy", core_rdy, 1);
      chk("postrst_mem_req", mem_req, 0);
      chk("postrst_dl", dl, 0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic       r, s;
      int         w;
      r = 1'($urandom_range(0, 1));
      s = r ? 1'($urandom_range(0, 1)) : 1'b0;
      w = ($urandom_range(0, 4) == 0) ? MAX_WAIT : int'($urandom_range(0, MAX_WAIT - 1));
      do_txn(16'($urandom), r, s, 8'($urandom), w, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("req_queue_empty", req_q.size(), 0);
    chk("comp_queue_empty", comp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
